touch_event_decoder: RTL
========================

// Module: touch_event_decoder
// PURPOSE
//  Consumer end of the combined touch signal. Takes the raw level `touched`
//  (high while both pads are held), then synchronises, debounces and
//  classifies it into TAP / DOUBLE_TAP / LONG_PRESS events.
//  Events go to game/control logic through a 1-deep valid/ready output
//  register. Sits between the touch sensor top and the main FSM.
// PARAMETERS
//  DEBOUNCE_CYCLES  1_000_000  stable cycles required before deb level changes (10 ms @100 MHz)
//  LONG_CYCLES      80_000_000 debounced-high cycles that make a long press (0.8 s)
//  GAP_CYCLES       25_000_000 max debounced-low cycles between taps of a double tap (0.25 s)
//  CNT_W            27         width of the hold/gap counter; must hold max(LONG,GAP)-1
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous, active-low reset (0 = reset)
//  touched    in   1  raw touch level, asynchronous to clk
//  evt_ready  in   1  consumer accepts evt when high with evt_valid
//  evt_valid  out  1  event pending
//  evt_code   out  2  01 TAP, 10 DOUBLE_TAP, 11 LONG_PRESS; 00 only when !evt_valid
//  evt_drop   out  1  1-cycle pulse: event lost because the output register was full
//  pressed    out  1  debounced touch level
// BEHAVIOUR
//  Reset (rst=0, async): sync flops=0, deb=0, counters=0, FSM=IDLE,
//   evt_valid=0, evt_code=00, evt_drop=0, pressed=0.
//  Sync: 2-flop synchroniser on touched -> s.
//  Debounce: dcnt counts while s!=deb and clears when s==deb.
//   - When dcnt reaches DEBOUNCE_CYCLES-1 with s!=deb: deb<=s, dcnt<=0.
//   - Raw change to pressed change = DEBOUNCE_CYCLES+2 clk edges.
//   - A glitch shorter than DEBOUNCE_CYCLES never reaches deb. pressed=deb.
//  FSM (driven by deb; rise/fall = deb edges; cnt is the CNT_W counter):
//   IDLE:     rise -> PRESS, cnt=0.
//   PRESS:    cnt++ while deb=1.
//             cnt==LONG_CYCLES-1 -> emit LONG, go WAIT_REL.
//             fall -> GAP, cnt=0.
//   GAP:      cnt++. rise -> emit DOUBLE, go WAIT_REL.
//             cnt==GAP_CYCLES-1 with no rise -> emit TAP, go IDLE.
//             If rise and timeout fall in the same cycle, rise wins (DOUBLE).
//   WAIT_REL: fall -> IDLE. No events while held, so a long second press is
//             still only DOUBLE.
//  Emit goes to the output register the cycle after the FSM decision
//   (1-cycle latency).
//  Output register:
//   - Holds evt_code stable while evt_valid=1 && evt_ready=0.
//   - Accept = evt_valid & evt_ready. On accept with no emit: evt_valid<=0, evt_code<=00.
//   - Emit together with accept: load new code, evt_valid stays 1.
//   - Emit while full and not accepting: event dropped, held event kept,
//     evt_drop=1 for 1 cycle.
//  Reset asserted mid-press or mid-gap: all state cleared. A press still held
//   after reset release is seen as a fresh rise after debounce.
//  Counters saturate, never wrap. CNT_W too small for LONG/GAP is a
//   parameter error (elaboration $error).
// TESTING (bench params: DEBOUNCE_CYCLES=4, LONG_CYCLES=20, GAP_CYCLES=10, evt_ready=1 unless noted)
//  1 touched high 8 cyc, then low -> after GAP timeout: one evt_valid pulse,
//    evt_code=01; pressed high 6 cyc after rise.
//  2 touched pulses 1-3 cyc long -> pressed stays 0, no event.
//  3 high 8, low 5, high 8 -> evt_code=10 exactly once, issued on the second
//    debounced rise; no TAP.
//  4 high 40 cyc -> evt_code=11 once, 20 cyc after pressed rises; nothing
//    on release.
//  5 evt_ready=0, make TAP then LONG -> evt_valid held with code 01, evt_drop
//    pulses once; raise ready -> 01 accepted, valid falls.
//  6 rst low during PRESS for 3 cyc -> all outputs 0 asynchronously; no event
//    after release until a new debounced press.

Source files
------------

// File: rtl/touch_event_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : touch_event_decoder
//  Description : Synchronises and debounces the combined touch level, then
//                classifies presses into TAP / DOUBLE_TAP / LONG_PRESS events
//                delivered through a 1-deep valid/ready output register.
//  Revision    : 1.0 - initial release
// ============================================================================
module touch_event_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 80_000_000,
  parameter int unsigned GAP_CYCLES      = 25_000_000,
  parameter int unsigned CNT_W           = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       touched,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  output logic       evt_drop,
  output logic       pressed
);

  localparam int unsigned c_dw = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [c_dw-1:0]  c_deb_last  = c_dw'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_long_last = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_gap_last  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};

  localparam logic [1:0] c_code_none   = 2'b00;
  localparam logic [1:0] c_code_tap    = 2'b01;
  localparam logic [1:0] c_code_double = 2'b10;
  localparam logic [1:0] c_code_long   = 2'b11;

  // The hold/gap counter must be able to reach both terminal counts.
  generate
    if ((64'(LONG_CYCLES) > (64'd1 << CNT_W)) || (64'(GAP_CYCLES) > (64'd1 << CNT_W))) begin : g_cnt_w_check
      $error("touch_event_decoder: CNT_W too small for LONG_CYCLES/GAP_CYCLES");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRESS    = 2'd1,
    ST_GAP      = 2'd2,
    ST_WAIT_REL = 2'd3
  } state_t;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_deb;
  logic [c_dw-1:0]  r_dcnt;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_deb_commit;
  logic             w_rise;
  logic             w_fall;
  logic             w_emit;
  logic [1:0]       w_emit_code;
  logic             r_evt_valid;
  logic [1:0]       r_evt_code;
  logic             r_evt_drop;

  // The debounced level changes on the edge where the stable count completes;
  // rise/fall mark that edge so the FSM moves in lockstep with deb.
  assign w_deb_commit = (r_sync2 != r_deb) && (r_dcnt == c_deb_last);
  assign w_rise       = w_deb_commit &  r_sync2;
  assign w_fall       = w_deb_commit & ~r_sync2;
  assign w_cnt_inc    = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;

  // Two-flop synchroniser for the asynchronous touch level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= touched;
      r_sync2 <= r_sync1;
    end
  end

  // Debouncer: deb follows s only after it has differed for DEBOUNCE_CYCLES.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_deb  <= 1'b0;
      r_dcnt <= '0;
    end else if (r_sync2 == r_deb) begin
      r_dcnt <= '0;
    end else if (w_deb_commit) begin
      r_deb  <= r_sync2;
      r_dcnt <= '0;
    end else begin
      r_dcnt <= r_dcnt + 1'b1;
    end
  end

  // Classifier state and hold/gap counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Classifier next state and event emission; a rise in GAP beats the timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_emit      = 1'b0;
    w_emit_code = c_code_none;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_nxt = ST_PRESS;
          w_cnt_nxt   = '0;
        end
      end
      ST_PRESS: begin
        if (r_cnt == c_long_last) begin
          w_emit      = 1'b1;
          w_emit_code = c_code_long;
          w_state_nxt = w_fall ? ST_IDLE : ST_WAIT_REL;
          w_cnt_nxt   = '0;
        end else if (w_fall) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
      end
      ST_GAP: begin
        if (w_rise) begin
          w_emit      = 1'b1;
          w_emit_code = c_code_double;
          w_state_nxt = ST_WAIT_REL;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_gap_last) begin
          w_emit      = 1'b1;
          w_emit_code = c_code_tap;
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
      end
      ST_WAIT_REL: begin
        if (w_fall) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output register: holds a pending event until accepted, drops new ones when full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_evt_valid <= 1'b0;
      r_evt_code  <= c_code_none;
      r_evt_drop  <= 1'b0;
    end else begin
      r_evt_drop <= w_emit & r_evt_valid & ~evt_ready;
      if (w_emit && (!r_evt_valid || evt_ready)) begin
        r_evt_valid <= 1'b1;
        r_evt_code  <= w_emit_code;
      end else if (r_evt_valid && evt_ready) begin
        r_evt_valid <= 1'b0;
        r_evt_code  <= c_code_none;
      end
    end
  end

  assign evt_valid = r_evt_valid;
  assign evt_code  = r_evt_code;
  assign evt_drop  = r_evt_drop;
  assign pressed   = r_deb;

endmodule
`default_nettype wire
